// File: rtl/fc_stream_loader.sv
// fc_stream_loader: deserialises an activation stream into the parallel x[] vector
// of a fully-connected layer. It holds x[] for SETTLE cycles while the layer's
// combinational path settles, then registers z_in and returns it on a valid/ready stream.
module fc_stream_loader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IN     = 128,
  parameter int unsigned OUT_W  = 23,
  parameter int unsigned SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_last,
  output logic [WIDTH-1:0]   x [0:IN-1],
  input  logic [OUT_W-1:0]   z_in,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               frm_err
);

  localparam int unsigned IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             frm_err_q, frm_err_d;
  logic [WIDTH-1:0] x_q [0:IN-1];
  logic             x_wr, x_clr;
  logic             accept;

  assign s_ready = (state_q == ST_FILL);
  assign accept  = s_valid & s_ready;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign frm_err = frm_err_q;
  assign x       = x_q;

  // Next-state and control decode for the fill / settle / output sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    frm_err_d = 1'b0;
    x_wr      = 1'b0;
    x_clr     = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          x_wr = 1'b1;
          if ((idx_q == IDX_LAST) || s_last) begin
            // Frame closes; a mismatch between beat count and s_last is flagged.
            state_d   = ST_SETTLE;
            cnt_d     = '0;
            frm_err_d = (idx_q == IDX_LAST) ^ s_last;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = ST_OUT;
          m_valid_d = 1'b1;
          m_data_d  = z_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d   = ST_FILL;
          m_valid_d = 1'b0;
          idx_d     = '0;
          x_clr     = 1'b1;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      idx_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      frm_err_q <= frm_err_d;
    end
  end

  // Activation vector: cleared on result handoff so short frames read zeros in the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(IN); i++) x_q[i] <= '0;
    end else if (x_clr) begin
      for (int i = 0; i < int'(IN); i++) x_q[i] <= '0;
    end else if (x_wr) begin
      x_q[idx_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_fc_stream_loader.sv
// Bench for fc_stream_loader: a behavioural model checked every cycle plus
// hand-computed literal results, and two small builds with SETTLE=1 and SETTLE=15.
module tb_fc_stream_loader;

  localparam int WIDTH  = 8;
  localparam int IN     = 128;
  localparam int OUT_W  = 23;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready, s_last;
  logic [WIDTH-1:0] s_data;
  logic [WIDTH-1:0] x [0:IN-1];
  logic [OUT_W-1:0] z_in, m_data;
  logic             m_valid, m_ready, frm_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the layer: weighted sum with weights 1,2,3 repeating.
  always_comb begin
    int acc;
    acc = 0;
    for (int i = 0; i < IN; i++) acc += int'(x[i]) * ((i % 3) + 1);
    z_in = OUT_W'(acc);
  end

  fc_stream_loader #(.WIDTH(WIDTH), .IN(IN), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .x(x), .z_in(z_in), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .frm_err(frm_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_phase;      // 0 collecting, 1 waiting for layer, 2 result offered
  int       m_idx, m_wait;
  int       m_x [0:IN-1];
  bit       m_mvalid, m_err;
  longint   m_mdata;

  function automatic longint dot();
    longint s;
    s = 0;
    for (int i = 0; i < IN; i++) s += longint'(m_x[i]) * ((i % 3) + 1);
    return s;
  endfunction

  task automatic mreset();
    m_phase = 0; m_idx = 0; m_wait = 0; m_mvalid = 0; m_err = 0; m_mdata = 0;
    for (int i = 0; i < IN; i++) m_x[i] = 0;
  endtask

  task automatic mstep();
    m_err = 0;
    case (m_phase)
      0: if (s_valid) begin
           m_x[m_idx] = int'(s_data);
           if (m_idx == IN - 1 || s_last) begin
             m_err   = (m_idx == IN - 1) != s_last;
             m_phase = 1;
             m_wait  = SETTLE;
           end else m_idx++;
         end
      1: begin
           m_wait--;
           if (m_wait == 0) begin m_mvalid = 1; m_mdata = dot(); m_phase = 2; end
         end
      default: if (m_ready) begin
           m_mvalid = 0; m_idx = 0; m_phase = 0;
           for (int i = 0; i < IN; i++) m_x[i] = 0;
         end
    endcase
  endtask

  // Compare process: outputs sampled on the falling edge against the model.
  initial begin
    mreset();
    forever begin
      int bad;
      @(negedge clk);
      if (!rst_n) mreset();
      chk("s_ready", 64'(s_ready), 64'(m_phase == 0));
      chk("m_valid", 64'(m_valid), 64'(m_mvalid));
      chk("m_data", 64'(m_data), 64'(m_mdata));
      chk("frm_err", 64'(frm_err), 64'(m_err));
      bad = -1;
      for (int i = 0; i < IN; i++) if (x[i] !== WIDTH'(m_x[i])) begin bad = i; break; end
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL x[%0d] act=%0d exp=%0d", bad, x[bad], m_x[bad]);
      end
      if (rst_n) mstep();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_frame(input int n, input int start, input bit last_at_end);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int guard;
      s_valid = 1'b1;
      s_data  = WIDTH'((start + k) & 255);
      s_last  = last_at_end && (k == n - 1);
      acc = 0; guard = 0;
      while (!acc) begin
        @(negedge clk); acc = s_ready;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 2000) begin
          chk("accept_timeout", 64'(0), 64'(1));
          s_valid = 1'b0; s_last = 1'b0;
          return;
        end
      end
    end
    last_acc_cyc = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Edges after the final accept until m_valid is seen; resumes just after a rising edge.
  task automatic wait_mvalid(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (m_valid || n >= 200) break;
      n++;
    end
    if (!m_valid) chk("mvalid_timeout", 64'(0), 64'(1));
  endtask

  task automatic resync();
    @(posedge clk); #1;
  endtask

  // ---------------- SETTLE=1 / SETTLE=15 builds ----------------
  for (genvar g = 0; g < 2; g++) begin : g_aux
    localparam int S = (g == 0) ? 1 : 15;
    logic       av, ar, al, amv, amr, aerr;
    logic [7:0] ad;
    logic [7:0] ax [0:3];
    logic [22:0] az, amd;
    bit         done = 0;

    assign az = 23'(ax[0]) + 23'(ax[1]) + 23'(ax[2]) + 23'(ax[3]);

    fc_stream_loader #(.WIDTH(8), .IN(4), .OUT_W(23), .SETTLE(S)) u_aux (
      .clk(clk), .rst_n(rst_n), .s_valid(av), .s_ready(ar), .s_data(ad), .s_last(al),
      .x(ax), .z_in(az), .m_valid(amv), .m_ready(amr), .m_data(amd), .frm_err(aerr)
    );

    initial begin
      int n;
      bit acc;
      av = 0; al = 0; ad = 0; amr = 1;
      wait (rst_n === 1'b1);
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        av = 1; ad = 8'(k + 1); al = (k == 3);
        acc = 0; n = 0;
        while (!acc && n < 100) begin
          @(negedge clk); acc = ar;
          @(posedge clk); #1;
          n++;
        end
      end
      av = 0; al = 0; n = 0;
      forever begin
        @(negedge clk);
        if (amv || n >= 100) break;
        n++;
      end
      chk($sformatf("aux_latency_S%0d", S), 64'(n), 64'(S));
      chk($sformatf("aux_mdata_S%0d", S), 64'(amd), 64'(10));
      chk($sformatf("aux_frm_err_S%0d", S), 64'(aerr), 64'(0));
      done = 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=%0d exp=%0d", cyc, 0);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, a1, a2, a3;
    rst_n = 0; s_valid = 0; s_data = '0; s_last = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_x127", 64'(x[127]), 64'(0));
    resync();
    rst_n = 1;
    resync();

    // 128-beat ramp
    send_frame(128, 0, 1);
    wait_mvalid(n);
    chk("ramp_latency", 64'(n), 64'(SETTLE));
    chk("ramp_mdata", 64'(m_data), 64'(16214));
    chk("ramp_x100", 64'(x[100]), 64'(100));
    resync();

    // short frame 1..5
    send_frame(5, 1, 1);
    @(negedge clk);
    chk("short_frm_err", 64'(frm_err), 64'(1));
    chk("short_x4", 64'(x[4]), 64'(5));
    chk("short_x5", 64'(x[5]), 64'(0));
    resync();
    wait_mvalid(n);
    chk("short_mdata", 64'(m_data), 64'(28));
    resync();

    // missing s_last, values 7..134
    send_frame(128, 7, 0);
    @(negedge clk);
    chk("nolast_frm_err", 64'(frm_err), 64'(1));
    resync();
    wait_mvalid(n);
    chk("nolast_mdata", 64'(m_data), 64'(17999));
    resync();

    // backpressure with the next beat waiting
    m_ready = 0;
    send_frame(128, 3, 1);
    s_valid = 1; s_data = 8'hAA; s_last = 0;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_s_ready", 64'(s_ready), 64'(0));
    chk("bp_m_valid", 64'(m_valid), 64'(1));
    resync();
    m_ready = 1;
    send_frame(1, 8'hAA, 0);
    @(negedge clk);
    chk("bp_release_x0", 64'(x[0]), 64'(8'hAA));
    resync();
    send_frame(127, 1, 1);
    wait_mvalid(n);
    resync();

    // reset in the middle of a fill
    send_frame(60, 9, 0);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_x0", 64'(x[0]), 64'(0));
    chk("midrst_m_valid", 64'(m_valid), 64'(0));
    chk("midrst_s_ready", 64'(s_ready), 64'(1));
    resync();
    rst_n = 1;
    resync();
    send_frame(128, 0, 1);
    wait_mvalid(n);
    chk("midrst_mdata", 64'(m_data), 64'(16214));
    resync();

    // back-to-back frames, continuous valid and ready
    send_frame(128, 0, 1); a1 = last_acc_cyc;
    send_frame(128, 0, 1); a2 = last_acc_cyc;
    send_frame(128, 0, 1); a3 = last_acc_cyc;
    chk("b2b_period1", 64'(a2 - a1), 64'(IN + SETTLE + 1));
    chk("b2b_period2", 64'(a3 - a2), 64'(IN + SETTLE + 1));
    wait_mvalid(n);
    chk("b2b_mdata", 64'(m_data), 64'(16214));
    resync();

    n = 0;
    while (!(g_aux[0].done && g_aux[1].done) && n < 1000) begin
      @(posedge clk); n++;
    end
    if (!(g_aux[0].done && g_aux[1].done)) chk("aux_done_timeout", 64'(0), 64'(1));
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
